count_flips_param: RTL and testbench
====================================

Name: count_flips_param

Overview:
- Parametrised successor to the per-line colour-flip counter in the marker_detect path.
- Consumes compressed pixels (rgb_compress output) one scan line at a time.
- Counts debounced colour transitions, recording first and last flip coordinates and the coordinate of every flip in a small buffer.
- Flags lines whose flip count matches the marker signature. Result and readback feed the downstream marker locator.

Parameters:
- PIXEL_WIDTH, 3, width of compressed pixel code.
- COORD_WIDTH, 11, width of pixel coordinate.
- LINE_LENGTH, 1680, pixels per scan line.
- MIN_RUN, 4, consecutive pixels of a new colour required to commit a flip (1 = no debounce).
- MAX_FLIPS, 15, saturation value of the flip counter and depth of the flip-coordinate buffer.
- TARGET_FLIPS, 6, flip count that marks a line as a marker candidate.
- CW, $clog2(MAX_FLIPS+1), derived counter width (localparam).

Ports:
- clk_in, in, 1, clock.
- rst_in, in, 1, asynchronous active-high reset.
- line_start_in, in, 1, synchronous: abort any scan and arm a new line.
- pixel_valid_in, in, 1, rgb_in is valid this cycle.
- rgb_in, in, PIXEL_WIDTH, compressed pixel.
- number_of_flips_out, out, CW, committed flips this line (saturating).
- first_coord_out, out, COORD_WIDTH, coordinate of first committed flip.
- last_coord_out, out, COORD_WIDTH, coordinate of most recent committed flip.
- match_out, out, 1, number_of_flips_out == TARGET_FLIPS; valid while done_out is high.
- done_out, out, 1, line complete; held until line_start_in.
- busy_out, out, 1, high in SCAN.
- rd_idx_in, in, CW, flip buffer read index.
- rd_coord_out, out, COORD_WIDTH, buffer[rd_idx_in], registered, 1-cycle latency; 0 if rd_idx_in >= number_of_flips_out.

Behaviour:
- Reset (async, rst_in=1):
  - state=IDLE.
  - All outputs 0; buffer contents don't-care, reads return 0 since the count is 0.
- States:
  - IDLE: line_start_in -> SCAN.
  - SCAN: accepts pixels. On the accepted pixel with coord == LINE_LENGTH-1 -> DONE.
  - DONE: line_start_in -> SCAN.
  - line_start_in in SCAN restarts SCAN: counters cleared, done_out=0.
- Entering SCAN clears coord, flips, first/last coords, candidate run and match_out.
- A pixel is accepted only when pixel_valid_in=1 in SCAN. Invalid cycles freeze all counters; they do not break a run.
- Coordinate
  - Coord of an accepted pixel = number of previously accepted pixels on this line.
  - line_start_in together with pixel_valid_in: that pixel is coord 0 of the new line.
- Coord 0 pixel loads stable colour and does not count as a flip.
- Debounce, for subsequent pixels:
  - pixel == stable: candidate run cleared.
  - pixel != stable and == candidate colour: run_len++.
  - Otherwise: candidate colour = pixel, run_len=1, run_start=coord.
  - When run_len reaches MIN_RUN (same cycle the pixel is accepted), commit a flip:
    - stable <= candidate; run cleared.
    - flips <= flips+1, saturating at MAX_FLIPS.
    - last_coord_out <= run_start.
    - first_coord_out <= run_start if this is the first flip.
    - buffer[flips] <= run_start, written only if flips < MAX_FLIPS.
  - Outputs update the cycle after the committing pixel.
  - With MIN_RUN=1, each differing pixel commits immediately.
- A candidate run still shorter than MIN_RUN at line end is discarded.
- done_out rises the cycle after the last pixel is accepted; match_out is updated in the same cycle.
- Pixels presented in IDLE/DONE are ignored.
- Counters have no wrap-around: coord stops at LINE_LENGTH-1 because the state leaves SCAN.
- Saturation: once flips=MAX_FLIPS, further flips update last_coord_out only; no buffer writes.
- Read port is usable in any state; a read concurrent with a write to the same index returns the old value.

Test Plan (bench overrides LINE_LENGTH=16, MIN_RUN=3, MAX_FLIPS=3, TARGET_FLIPS=2):
- Reset mid-SCAN after 5 pixels -> all outputs 0 immediately (async); busy_out=0; subsequent pixels ignored until line_start_in.
- Pixels 0,0,0,0,5,5,5,5,5,5,0,0,0,0,0,0 -> flips=2; first=4; last=10; match_out=1; done_out high the cycle after pixel 15; rd_idx 0/1 -> 4/10; rd_idx 2 -> 0.
- Glitch line 1,1,1,2,2,1,1,1,1,1,1,1,1,1,1,1 -> flips=0; match_out=0 (run of 2 < MIN_RUN).
- Alternating runs of 3: 0,0,0,1,1,1,0,0,0,1,1,1,0,0,0,1 -> flips saturate at 3; buffer={3,6,9}; last=12; final single 1 discarded.
- pixel_valid_in low for 4 cycles in the middle of a 3-pixel run -> flip still committed with the correct run_start; done_out only after 16 accepted pixels.
- line_start_in asserted at coord 8 with a simultaneous valid pixel -> that pixel is coord 0; previous line's flips discarded; done_out after 16 further pixels.

Source files
------------

// File: rtl/count_flips_param.sv
// count_flips_param
//
// Purpose:
//   Per-scan-line colour-flip counter for the marker_detect path. It consumes
//   compressed pixels (rgb_compress output) one line at a time. It debounces
//   colour changes: a new colour must persist for MIN_RUN accepted pixels
//   before it counts as a flip. For each line it records the flip count,
//   the coordinates of the first and last flips, and the coordinate of every
//   flip in a small buffer. It also flags lines whose flip count equals
//   TARGET_FLIPS.
//
// Ports:
//   clk_in              clock
//   rst_in              asynchronous active-high reset
//   line_start_in       abort any scan and arm a new line (pixel this cycle is coord 0)
//   pixel_valid_in      rgb_in carries a pixel this cycle
//   rgb_in              compressed pixel code
//   number_of_flips_out committed flips this line (saturates at MAX_FLIPS)
//   first_coord_out     start coordinate of the first committed flip
//   last_coord_out      start coordinate of the most recent committed flip
//   match_out           flip count equals TARGET_FLIPS (valid while done_out)
//   done_out            line complete, held until the next line_start_in
//   busy_out            scanning a line
//   rd_idx_in           flip buffer read index
//   rd_coord_out        buffer[rd_idx_in] one cycle later, 0 past the flip count

module count_flips_param #(
  parameter int PIXEL_WIDTH  = 3,
  parameter int COORD_WIDTH  = 11,
  parameter int LINE_LENGTH  = 1680,
  parameter int MIN_RUN      = 4,
  parameter int MAX_FLIPS    = 15,
  parameter int TARGET_FLIPS = 6,
  localparam int CW          = $clog2(MAX_FLIPS + 1)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   line_start_in,
  input  logic                   pixel_valid_in,
  input  logic [PIXEL_WIDTH-1:0] rgb_in,
  output logic [CW-1:0]          number_of_flips_out,
  output logic [COORD_WIDTH-1:0] first_coord_out,
  output logic [COORD_WIDTH-1:0] last_coord_out,
  output logic                   match_out,
  output logic                   done_out,
  output logic                   busy_out,
  input  logic [CW-1:0]          rd_idx_in,
  output logic [COORD_WIDTH-1:0] rd_coord_out
);

  localparam int RW = $clog2(MIN_RUN + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   busy, busy_nxt;
  logic                   done, done_nxt;
  logic                   match, match_nxt;
  logic [COORD_WIDTH-1:0] coord, coord_nxt;
  logic [CW-1:0]          flips, flips_nxt;
  logic [COORD_WIDTH-1:0] first_coord, first_nxt;
  logic [COORD_WIDTH-1:0] last_coord, last_nxt;
  logic [PIXEL_WIDTH-1:0] stable, stable_nxt;
  logic [PIXEL_WIDTH-1:0] cand, cand_nxt;
  logic [RW-1:0]          run_len, run_len_nxt;
  logic [COORD_WIDTH-1:0] run_start, run_start_nxt;

  logic                   wr_en;
  logic [CW-1:0]          wr_idx;
  logic [COORD_WIDTH-1:0] wr_data;
  logic [COORD_WIDTH-1:0] flip_buf [0:MAX_FLIPS-1];
  logic [COORD_WIDTH-1:0] rd_coord;

  // The restart is applied to the *_nxt copies first. A pixel that arrives
  // with line_start_in is then processed against the cleared values, which
  // makes it coord 0 of the new line. run_len == 0 means no candidate, so a
  // stale candidate colour can never extend a run with an old run_start.
  always_comb begin
    state_nxt     = state;
    busy_nxt      = busy;
    done_nxt      = done;
    match_nxt     = match;
    coord_nxt     = coord;
    flips_nxt     = flips;
    first_nxt     = first_coord;
    last_nxt      = last_coord;
    stable_nxt    = stable;
    cand_nxt      = cand;
    run_len_nxt   = run_len;
    run_start_nxt = run_start;
    wr_en         = 1'b0;
    wr_idx        = flips;
    wr_data       = run_start;

    if (line_start_in) begin
      state_nxt     = SCAN;
      busy_nxt      = 1'b1;
      done_nxt      = 1'b0;
      match_nxt     = 1'b0;
      coord_nxt     = '0;
      flips_nxt     = '0;
      first_nxt     = '0;
      last_nxt      = '0;
      stable_nxt    = '0;
      cand_nxt      = '0;
      run_len_nxt   = '0;
      run_start_nxt = '0;
    end

    if (pixel_valid_in && (line_start_in || state == SCAN)) begin
      if (coord_nxt == '0) begin
        stable_nxt  = rgb_in;
        run_len_nxt = '0;
      end else if (rgb_in == stable_nxt) begin
        run_len_nxt = '0;
      end else begin
        if (run_len_nxt != '0 && rgb_in == cand_nxt) begin
          run_len_nxt = run_len_nxt + RW'(1);
        end else begin
          cand_nxt      = rgb_in;
          run_len_nxt   = RW'(1);
          run_start_nxt = coord_nxt;
        end
        // Commit in the same cycle the run reaches MIN_RUN.
        if (run_len_nxt == RW'(MIN_RUN)) begin
          stable_nxt  = cand_nxt;
          run_len_nxt = '0;
          if (flips_nxt == '0) begin
            first_nxt = run_start_nxt;
          end
          last_nxt = run_start_nxt;
          if (flips_nxt < CW'(MAX_FLIPS)) begin
            wr_en     = 1'b1;
            wr_idx    = flips_nxt;
            wr_data   = run_start_nxt;
            flips_nxt = flips_nxt + CW'(1);
          end
        end
      end

      // An unfinished candidate run is simply dropped when the line ends.
      if (coord_nxt == COORD_WIDTH'(LINE_LENGTH - 1)) begin
        state_nxt = DONE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        match_nxt = (flips_nxt == CW'(TARGET_FLIPS));
      end else begin
        coord_nxt = coord_nxt + COORD_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      match       <= 1'b0;
      coord       <= '0;
      flips       <= '0;
      first_coord <= '0;
      last_coord  <= '0;
      stable      <= '0;
      cand        <= '0;
      run_len     <= '0;
      run_start   <= '0;
    end else begin
      state       <= state_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      match       <= match_nxt;
      coord       <= coord_nxt;
      flips       <= flips_nxt;
      first_coord <= first_nxt;
      last_coord  <= last_nxt;
      stable      <= stable_nxt;
      cand        <= cand_nxt;
      run_len     <= run_len_nxt;
      run_start   <= run_start_nxt;
    end
  end

  // Buffer contents are don't-care after reset; reads are gated by the count.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      flip_buf[wr_idx] <= wr_data;
    end
  end

  // A read that hits the index being written this cycle sees the old value.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_coord <= '0;
    end else if (rd_idx_in < flips) begin
      rd_coord <= flip_buf[rd_idx_in];
    end else begin
      rd_coord <= '0;
    end
  end

  assign number_of_flips_out = flips;
  assign first_coord_out     = first_coord;
  assign last_coord_out      = last_coord;
  assign match_out           = match;
  assign done_out            = done;
  assign busy_out            = busy;
  assign rd_coord_out        = rd_coord;

endmodule

// File: tb/tb_count_flips_param.sv
// tb_count_flips_param
//
// Purpose:
//   Directed and randomized bench for count_flips_param with a short line
//   (16 pixels), MIN_RUN=3, MAX_FLIPS=3 and TARGET_FLIPS=2. The expected
//   results come from a run-length reference model. The model splits the
//   accepted pixels of a line into maximal runs of equal colour. A run that
//   differs from the stable colour and is at least MIN_RUN long is a flip
//   starting at the run's first coordinate.
//
// Ports: none (top-level bench).

module tb_count_flips_param;

  localparam int PW   = 3;
  localparam int CWD  = 11;
  localparam int LEN  = 16;
  localparam int MINR = 3;
  localparam int MAXF = 3;
  localparam int TGT  = 2;
  localparam int CW   = $clog2(MAXF + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           line_start;
  logic           pixel_valid;
  logic [PW-1:0]  rgb;
  logic [CW-1:0]  flips;
  logic [CWD-1:0] first_coord;
  logic [CWD-1:0] last_coord;
  logic           match;
  logic           done;
  logic           busy;
  logic [CW-1:0]  rd_idx;
  logic [CWD-1:0] rd_coord;

  int checks      = 0;
  int miscompares = 0;

  logic [PW-1:0] px [0:LEN-1];
  int m_flips;
  int m_first;
  int m_last;
  int m_buf [0:MAXF-1];

  count_flips_param #(
    .PIXEL_WIDTH (PW),
    .COORD_WIDTH (CWD),
    .LINE_LENGTH (LEN),
    .MIN_RUN     (MINR),
    .MAX_FLIPS   (MAXF),
    .TARGET_FLIPS(TGT)
  ) dut (
    .clk_in             (clk),
    .rst_in             (rst),
    .line_start_in      (line_start),
    .pixel_valid_in     (pixel_valid),
    .rgb_in             (rgb),
    .number_of_flips_out(flips),
    .first_coord_out    (first_coord),
    .last_coord_out     (last_coord),
    .match_out          (match),
    .done_out           (done),
    .busy_out           (busy),
    .rd_idx_in          (rd_idx),
    .rd_coord_out       (rd_coord)
  );

  always #5 clk = ~clk;

  // Reference model over the first n accepted pixels of px.
  task automatic compute_model(input int n);
    int i;
    int run;
    logic [PW-1:0] st;
    m_flips = 0;
    m_first = 0;
    m_last  = 0;
    for (int k = 0; k < MAXF; k++) m_buf[k] = 0;
    if (n > 0) begin
      st = px[0];
      i  = 1;
      while (i < n) begin
        if (px[i] == st) begin
          i++;
        end else begin
          run = 1;
          while (i + run < n && px[i + run] == px[i]) run++;
          if (run >= MINR) begin
            if (m_flips == 0) m_first = i;
            m_last = i;
            if (m_flips < MAXF) begin
              m_buf[m_flips] = i;
              m_flips++;
            end
            st = px[i];
          end
          i += run;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Optional invalid cycles, then one valid pixel; sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic ls, input logic [PW-1:0] p, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      line_start  = 1'b0;
      pixel_valid = 1'b0;
      rgb         = PW'($urandom_range(0, 7));
      @(posedge clk);
      #1;
    end
    line_start  = ls;
    pixel_valid = 1'b1;
    rgb         = p;
    @(posedge clk);
    #1;
    line_start  = 1'b0;
    pixel_valid = 1'b0;
  endtask

  // Feed px[0..count-1] with line_start on pixel 0, checking live outputs.
  task automatic feed_line(input int count, input int gap_pos, input int gap_len);
    for (int c = 0; c < count; c++) begin
      applyStimulus(c == 0, px[c], (c == gap_pos) ? gap_len : 0);
      compute_model(c + 1);
      checkOutput("live_flips", 32'(flips), 32'(m_flips));
      checkOutput("live_first", 32'(first_coord), 32'(m_first));
      checkOutput("live_last", 32'(last_coord), 32'(m_last));
      checkOutput("live_done", 32'(done), 32'(c == LEN - 1));
      checkOutput("live_busy", 32'(busy), 32'(c != LEN - 1));
    end
  endtask

  task automatic check_line_end();
    compute_model(LEN);
    checkOutput("end_flips", 32'(flips), 32'(m_flips));
    checkOutput("end_first", 32'(first_coord), 32'(m_first));
    checkOutput("end_last", 32'(last_coord), 32'(m_last));
    checkOutput("end_match", 32'(match), 32'(m_flips == TGT));
    checkOutput("end_done", 32'(done), 32'd1);
    checkOutput("end_busy", 32'(busy), 32'd0);
    for (int i = 0; i < (1 << CW); i++) begin
      rd_idx = CW'(i);
      @(posedge clk);
      #1;
      checkOutput("readback", 32'(rd_coord), (i < m_flips) ? 32'(m_buf[i]) : 32'd0);
    end
    // A pixel in DONE is ignored and done_out stays held.
    applyStimulus(1'b0, PW'(7), 0);
    checkOutput("done_ignore_flips", 32'(flips), 32'(m_flips));
    checkOutput("done_held", 32'(done), 32'd1);
  endtask

  task automatic random_line();
    int c;
    int run;
    logic [PW-1:0] v;
    c = 0;
    while (c < LEN) begin
      v   = PW'($urandom_range(0, 3));
      run = $urandom_range(1, 4);
      for (int k = 0; k < run && c < LEN; k++) begin
        px[c] = v;
        c++;
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    line_start  = 1'b0;
    pixel_valid = 1'b0;
    rgb         = '0;
    rd_idx      = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_flips", 32'(flips), 32'd0);
    checkOutput("rst_first", 32'(first_coord), 32'd0);
    checkOutput("rst_last", 32'(last_coord), 32'd0);
    checkOutput("rst_match", 32'(match), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rd", 32'(rd_coord), 32'd0);
    #2 rst = 1'b0;

    $display("[TB] reference line with two flips");
    px = '{0, 0, 0, 0, 5, 5, 5, 5, 5, 5, 0, 0, 0, 0, 0, 0};
    feed_line(LEN, -1, 0);
    check_line_end();

    $display("[TB] glitch line");
    px = '{1, 1, 1, 2, 2, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    feed_line(LEN, -1, 0);
    check_line_end();

    $display("[TB] saturation line");
    px = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    feed_line(LEN, -1, 0);
    check_line_end();

    $display("[TB] invalid gap inside a run");
    px = '{2, 2, 2, 2, 6, 6, 6, 2, 2, 2, 2, 2, 2, 2, 2, 2};
    feed_line(LEN, 5, 4);
    check_line_end();

    $display("[TB] restart at coord 8");
    px = '{0, 0, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    feed_line(8, -1, 0);
    px = '{4, 4, 4, 4, 1, 1, 1, 1, 4, 4, 4, 4, 4, 4, 4, 4};
    feed_line(LEN, -1, 0);
    check_line_end();

    $display("[TB] reset in the middle of a scan");
    px = '{0, 0, 0, 7, 7, 7, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0};
    feed_line(5, -1, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_flips", 32'(flips), 32'd0);
    checkOutput("async_first", 32'(first_coord), 32'd0);
    checkOutput("async_last", 32'(last_coord), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_done", 32'(done), 32'd0);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, PW'(k + 2), 0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_flips", 32'(flips), 32'd0);
      checkOutput("idle_done", 32'(done), 32'd0);
    end
    px = '{3, 3, 3, 5, 5, 5, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    feed_line(LEN, -1, 0);
    check_line_end();

    $display("[TB] randomized lines");
    for (int l = 0; l < 8; l++) begin
      random_line();
      feed_line(LEN, $urandom_range(1, LEN - 1), $urandom_range(0, 3));
      check_line_end();
    end

    $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
    $finish;
  end

endmodule
